// File: rtl/pulp_soc_bus_pkg.sv
// Shared constants and helpers for the PULP SoC bus adapters.
package pulp_soc_bus_pkg;

    localparam int DEF_MAX_OUTSTANDING = 2;
    localparam int DEF_TIMEOUT         = 256;

    // Width of a counter able to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/obi_pulp_bridge_if.sv
// OBI (core side) and PULP TCDM (memory side) signal bundle for one bridge port.
// The slave modport is the bridge's view; master is the core/memory environment.
interface obi_pulp_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // OBI side
    logic                    obi_req_i;
    logic                    obi_gnt_o;
    logic [ADDR_WIDTH-1:0]   obi_addr_i;
    logic                    obi_we_i;
    logic [DATA_WIDTH/8-1:0] obi_be_i;
    logic [DATA_WIDTH-1:0]   obi_wdata_i;
    logic                    obi_rvalid_o;
    logic [DATA_WIDTH-1:0]   obi_rdata_o;
    logic                    obi_err_o;

    // PULP TCDM side
    logic                    mem_req_o;
    logic                    mem_gnt_i;
    logic [ADDR_WIDTH-1:0]   mem_add_o;
    logic                    mem_wen_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic [DATA_WIDTH/8-1:0] mem_be_o;
    logic                    mem_r_valid_i;
    logic [DATA_WIDTH-1:0]   mem_r_rdata_i;
    logic                    mem_r_opc_i;

    modport slave (
        input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        output mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_r_valid_i, mem_r_rdata_i, mem_r_opc_i
    );

    modport master (
        output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        input  mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_r_valid_i, mem_r_rdata_i, mem_r_opc_i
    );

endinterface

// File: rtl/obi_pulp_bridge_wdog.sv
// Response watchdog: counts cycles the oldest live transaction has waited and
// fires once the wait reaches TIMEOUT cycles without a delivered response.
module obi_pulp_bridge_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic live_nonzero,
    input  logic rsp_delivered,
    input  logic first_grant,
    output logic fire
);

    if (TIMEOUT == 0) begin : g_no_wdog
        assign fire = 1'b0;
    end else begin : g_wdog
        localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

        logic [TW-1:0] timer_q;
        logic [TW-1:0] timer_d;

        // A real response in the expiry cycle takes priority over the error.
        assign fire = live_nonzero && !rsp_delivered && (timer_q == LIMIT);

        // Restart on every delivered/synthesised response and on the grant that
        // opens a new busy period; otherwise count while anything is owed.
        always_comb begin
            timer_d = timer_q;
            if (!live_nonzero || rsp_delivered || first_grant || fire) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        // Timer register.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_d;
            end
        end
    end

endmodule

// File: rtl/obi_pulp_bridge.sv
// OBI-to-PULP-TCDM bridge with up to MAX_OUTSTANDING in-order transactions and
// a response watchdog that substitutes an error when memory stays silent.
module obi_pulp_bridge
    import pulp_soc_bus_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int TIMEOUT         = DEF_TIMEOUT
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    obi_pulp_bridge_if.slave                    bus,
    output logic [cnt_w(MAX_OUTSTANDING)-1:0]   outstanding_o,
    output logic                                timeout_o
);

    localparam int CW = cnt_w(MAX_OUTSTANDING);
    localparam logic [CW:0] SLOT_MAX = (CW + 1)'(MAX_OUTSTANDING);

    // live: owed a response to the core; discard: timed out, memory still owes one.
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW:0]   used;
    logic [CW:0]   used_eff;
    logic          gnt;
    logic          rsp_real;
    logic          rsp_drop;
    logic          fire;

    // Slot accounting: a response arriving this cycle frees its slot at once so
    // a waiting request can be granted in the same cycle.
    always_comb begin
        used     = {1'b0, live_q} + {1'b0, discard_q};
        used_eff = used;
        if (bus.mem_r_valid_i && (used != '0)) begin
            used_eff = used - (CW + 1)'(1);
        end
    end

    assign bus.mem_req_o   = bus.obi_req_i && !rst_i && (used_eff < SLOT_MAX);
    assign gnt             = bus.mem_req_o && bus.mem_gnt_i;
    assign bus.obi_gnt_o   = gnt;
    assign bus.mem_add_o   = bus.obi_addr_i;
    assign bus.mem_wen_o   = ~bus.obi_we_i;
    assign bus.mem_wdata_o = bus.obi_wdata_i;
    assign bus.mem_be_o    = bus.obi_be_i;

    // Responses belonging to timed-out transactions are swallowed in order.
    assign rsp_drop = bus.mem_r_valid_i && (discard_q != '0);
    assign rsp_real = bus.mem_r_valid_i && (discard_q == '0);

    assign bus.obi_rvalid_o = !rst_i && (rsp_real || fire);
    assign bus.obi_rdata_o  = rsp_real ? bus.mem_r_rdata_i : '0;
    assign bus.obi_err_o    = rsp_real ? bus.mem_r_opc_i : fire;
    assign timeout_o        = fire && !rst_i;
    assign outstanding_o    = live_q;

    obi_pulp_bridge_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .live_nonzero  (live_q != '0),
        .rsp_delivered (rsp_real),
        .first_grant   (gnt && (live_q == '0)),
        .fire          (fire)
    );

    // Counter next state; issue gating keeps both within 0..MAX_OUTSTANDING.
    always_comb begin
        live_d    = live_q;
        discard_d = discard_q;
        if (gnt) begin
            live_d = live_d + CW'(1);
        end
        if (rsp_real || fire) begin
            live_d = live_d - CW'(1);
        end
        if (fire) begin
            discard_d = discard_d + CW'(1);
        end
        if (rsp_drop) begin
            discard_d = discard_d - CW'(1);
        end
    end

    // Counter registers; in-flight state is dropped on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            live_q    <= '0;
            discard_q <= '0;
        end else begin
            live_q    <= live_d;
            discard_q <= discard_d;
        end
    end

`ifndef SYNTHESIS
    // Memory must never answer when nothing is in flight.
    a_no_spurious_rsp: assert property (
        @(posedge clk_i) disable iff (rst_i) bus.mem_r_valid_i |-> (used != '0)
    );
`endif

endmodule
